// File: rtl/mips_wb_pkg.sv
// rtl/mips_wb_pkg.sv - shared constants for the MEM/WB write-back stage
package mips_wb_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   localparam logic [1:0] WB_SEL_ALU  = 2'b00;
   localparam logic [1:0] WB_SEL_LOAD = 2'b01;
   localparam logic [1:0] WB_SEL_LINK = 2'b10;

   localparam logic [2:0] LD_LW  = 3'b000;
   localparam logic [2:0] LD_LH  = 3'b001;
   localparam logic [2:0] LD_LHU = 3'b010;
   localparam logic [2:0] LD_LB  = 3'b011;
   localparam logic [2:0] LD_LBU = 3'b100;

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - big-endian byte/half selection and extension of load data
module load_align
   import mips_wb_pkg::*;
(
   input  logic [2:0]        load_type_i,
   input  logic [1:0]        byte_off_i,
   input  logic [DATA_W-1:0] rdata_i,
   output logic [DATA_W-1:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      // Byte lane 0 is the most significant byte.
      case (byte_off_i)
         2'd0:    byte_sel = rdata_i[31:24];
         2'd1:    byte_sel = rdata_i[23:16];
         2'd2:    byte_sel = rdata_i[15:8];
         default: byte_sel = rdata_i[7:0];
      endcase
      half_sel = byte_off_i[1] ? rdata_i[15:0] : rdata_i[31:16];

      case (load_type_i)
         LD_LH:   data_o = {{16{half_sel[15]}}, half_sel};
         LD_LHU:  data_o = {16'h0000, half_sel};
         LD_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
         LD_LBU:  data_o = {24'h000000, byte_sel};
         default: data_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register, write-back mux and retire counter
// Optional WB_FWD_EN drives the fwd_* bypass ports; otherwise they are tied to 0.
module mem_wb_stage #(
   parameter int DATA_W = mips_wb_pkg::DATA_W,
   parameter int ADDR_W = mips_wb_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush_i,
   input  logic              in_valid,
   input  logic              in_reg_write,
   input  logic [ADDR_W-1:0] in_dst_addr,
   input  logic [1:0]        in_wb_sel,
   input  logic [2:0]        in_load_type,
   input  logic [1:0]        in_byte_off,
   input  logic [DATA_W-1:0] in_alu_result,
   input  logic [DATA_W-1:0] in_mem_rdata,
   input  logic [DATA_W-1:0] in_pc_plus8,
   output logic              reg_write_en,
   output logic [ADDR_W-1:0] reg_write_addr,
   output logic [DATA_W-1:0] reg_write_data,
   output logic [31:0]       retire_count,
   output logic              fwd_valid,
   output logic [ADDR_W-1:0] fwd_addr,
   output logic [DATA_W-1:0] fwd_data
);
   import mips_wb_pkg::*;

   logic              valid_q, valid_d;
   logic              reg_write_q, reg_write_d;
   logic [ADDR_W-1:0] dst_q, dst_d;
   logic [1:0]        wb_sel_q, wb_sel_d;
   logic [2:0]        load_type_q, load_type_d;
   logic [1:0]        byte_off_q, byte_off_d;
   logic [DATA_W-1:0] alu_q, alu_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [DATA_W-1:0] pc8_q, pc8_d;
   logic [31:0]       retire_q, retire_d;
   logic [DATA_W-1:0] load_data;

   // A flush only kills valid; the data fields are don't-care in a bubble.
   always_comb begin
      valid_d     = in_valid & ~flush_i;
      reg_write_d = in_reg_write;
      dst_d       = in_dst_addr;
      wb_sel_d    = in_wb_sel;
      load_type_d = in_load_type;
      byte_off_d  = in_byte_off;
      alu_d       = in_alu_result;
      rdata_d     = in_mem_rdata;
      pc8_d       = in_pc_plus8;
      retire_d    = retire_q + 32'(valid_q);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         valid_q     <= 1'b0;
         reg_write_q <= 1'b0;
         dst_q       <= '0;
         wb_sel_q    <= '0;
         load_type_q <= '0;
         byte_off_q  <= '0;
         alu_q       <= '0;
         rdata_q     <= '0;
         pc8_q       <= '0;
         retire_q    <= '0;
      end else begin
         valid_q     <= valid_d;
         reg_write_q <= reg_write_d;
         dst_q       <= dst_d;
         wb_sel_q    <= wb_sel_d;
         load_type_q <= load_type_d;
         byte_off_q  <= byte_off_d;
         alu_q       <= alu_d;
         rdata_q     <= rdata_d;
         pc8_q       <= pc8_d;
         retire_q    <= retire_d;
      end
   end

   load_align u_load_align (
      .load_type_i (load_type_q),
      .byte_off_i  (byte_off_q),
      .rdata_i     (rdata_q),
      .data_o      (load_data)
   );

   always_comb begin
      case (wb_sel_q)
         WB_SEL_LOAD: reg_write_data = load_data;
         WB_SEL_LINK: reg_write_data = pc8_q;
         default:     reg_write_data = alu_q;
      endcase
   end

   assign reg_write_addr = dst_q;
   assign reg_write_en   = valid_q & reg_write_q & (dst_q != '0);
   assign retire_count   = retire_q;

`ifdef WB_FWD_EN
   assign fwd_valid = reg_write_en;
   assign fwd_addr  = reg_write_addr;
   assign fwd_data  = reg_write_data;
`else
   assign fwd_valid = 1'b0;
   assign fwd_addr  = '0;
   assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - self-checking bench for mem_wb_stage
module tb_mem_wb_stage;

   logic        clk;
   logic        reset;
   logic        flush_i;
   logic        in_valid;
   logic        in_reg_write;
   logic [4:0]  in_dst_addr;
   logic [1:0]  in_wb_sel;
   logic [2:0]  in_load_type;
   logic [1:0]  in_byte_off;
   logic [31:0] in_alu_result;
   logic [31:0] in_mem_rdata;
   logic [31:0] in_pc_plus8;
   logic        reg_write_en;
   logic [4:0]  reg_write_addr;
   logic [31:0] reg_write_data;
   logic [31:0] retire_count;
   logic        fwd_valid;
   logic [4:0]  fwd_addr;
   logic [31:0] fwd_data;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference state: what the write port should show after the last edge.
   bit          m_valid;
   bit          m_en;
   logic [4:0]  m_addr;
   logic [31:0] m_data;
   logic [31:0] m_count;

   mem_wb_stage dut (
      .clk            (clk),
      .reset          (reset),
      .flush_i        (flush_i),
      .in_valid       (in_valid),
      .in_reg_write   (in_reg_write),
      .in_dst_addr    (in_dst_addr),
      .in_wb_sel      (in_wb_sel),
      .in_load_type   (in_load_type),
      .in_byte_off    (in_byte_off),
      .in_alu_result  (in_alu_result),
      .in_mem_rdata   (in_mem_rdata),
      .in_pc_plus8    (in_pc_plus8),
      .reg_write_en   (reg_write_en),
      .reg_write_addr (reg_write_addr),
      .reg_write_data (reg_write_data),
      .retire_count   (retire_count),
      .fwd_valid      (fwd_valid),
      .fwd_addr       (fwd_addr),
      .fwd_data       (fwd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] ref_data(input int sel, input int lt, input int off,
                                            input logic [31:0] alu, input logic [31:0] rd,
                                            input logic [31:0] pc8);
      longint unsigned b, h;
      b = (longint'(rd) >> (8 * (3 - off))) & 255;
      h = (longint'(rd) >> (16 * (1 - off / 2))) & 65535;
      if (sel == 2) return pc8;
      if (sel != 1) return alu;
      case (lt)
         1:       return 32'((h >= 32768) ? h + 64'hFFFF0000 : h);
         2:       return 32'(h);
         3:       return 32'((b >= 128) ? b + 64'hFFFFFF00 : b);
         4:       return 32'(b);
         default: return rd;
      endcase
   endfunction

   task automatic present(input bit v, input bit rw, input logic [4:0] dst, input logic [1:0] sel,
                          input logic [2:0] lt, input logic [1:0] off, input logic [31:0] alu,
                          input logic [31:0] rd, input logic [31:0] pc8);
      in_valid = v; in_reg_write = rw; in_dst_addr = dst; in_wb_sel = sel;
      in_load_type = lt; in_byte_off = off; in_alu_result = alu;
      in_mem_rdata = rd; in_pc_plus8 = pc8;
   endtask

   // Advance one clock edge, updating the reference from the spec's rules.
   task automatic step();
      @(posedge clk);
      if (!reset) begin
         m_valid = 0; m_en = 0; m_addr = '0; m_data = '0; m_count = '0;
      end else begin
         if (m_valid) m_count = m_count + 32'd1;
         m_valid = in_valid && !flush_i;
         m_en    = m_valid && in_reg_write && (in_dst_addr != 5'd0);
         m_addr  = in_dst_addr;
         m_data  = ref_data(int'(in_wb_sel), int'(in_load_type), int'(in_byte_off),
                            in_alu_result, in_mem_rdata, in_pc_plus8);
      end
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; flush_i = 1'b0;
      present(1, 1, 5'd3, 2'd0, 3'd0, 2'd0, 32'hDEADBEEF, 32'h1, 32'h2);
      step(); step();
      n_cmp++; if (reg_write_en !== 1'b0) begin n_bad++; $display("FAIL reset_en got %b want 0", reg_write_en); end
      n_cmp++; if (reg_write_addr !== 5'd0) begin n_bad++; $display("FAIL reset_addr got %0d want 0", reg_write_addr); end
      n_cmp++; if (reg_write_data !== 32'd0) begin n_bad++; $display("FAIL reset_data got %h want 0", reg_write_data); end
      n_cmp++; if (retire_count !== 32'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", retire_count); end
      n_cmp++; if ({fwd_valid, fwd_addr, fwd_data} !== '0) begin n_bad++; $display("FAIL reset_fwd got %b/%0d/%h want 0", fwd_valid, fwd_addr, fwd_data); end
      reset = 1'b1;
   endtask

   task automatic test_alu();
      present(1, 1, 5'd8, 2'd0, 3'd0, 2'd0, 32'h12345678, 32'h0, 32'h0);
      step();
      n_cmp++; if (reg_write_en !== 1'b1) begin n_bad++; $display("FAIL alu_en got %b want 1", reg_write_en); end
      n_cmp++; if (reg_write_addr !== 5'd8) begin n_bad++; $display("FAIL alu_addr got %0d want 8", reg_write_addr); end
      n_cmp++; if (reg_write_data !== 32'h12345678) begin n_bad++; $display("FAIL alu_data got %h want 12345678", reg_write_data); end
      n_cmp++; if (retire_count !== 32'd0) begin n_bad++; $display("FAIL alu_count0 got %0d want 0", retire_count); end
      present(0, 0, 5'd0, 2'd0, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0);
      step();
      n_cmp++; if (retire_count !== 32'd1) begin n_bad++; $display("FAIL alu_count1 got %0d want 1", retire_count); end
   endtask

   task automatic test_loads();
      logic [2:0]  lt  [5] = '{3'd3, 3'd4, 3'd1, 3'd2, 3'd0};
      logic [1:0]  off [5] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd0};
      logic [31:0] exp [5] = '{32'hFFFFFF80, 32'h000000FF, 32'h00007F01, 32'h000080FF, 32'h80FF7F01};
      for (int i = 0; i < 5; i++) begin
         present(1, 1, 5'd9, 2'd1, lt[i], off[i], 32'hAAAA5555, 32'h80FF7F01, 32'h0);
         step();
         n_cmp++;
         if (reg_write_data !== exp[i] || reg_write_en !== 1'b1) begin
            n_bad++; $display("FAIL load_%0d got en=%b data=%h want en=1 data=%h", i, reg_write_en, reg_write_data, exp[i]);
         end
      end
   endtask

   task automatic test_link_zero();
      logic [31:0] c0;
      present(1, 1, 5'd31, 2'd2, 3'd0, 2'd0, 32'h11111111, 32'h22222222, 32'h00400010);
      step();
      n_cmp++; if (reg_write_en !== 1'b1 || reg_write_data !== 32'h00400010 || reg_write_addr !== 5'd31) begin
         n_bad++; $display("FAIL link got en=%b addr=%0d data=%h want en=1 addr=31 data=00400010", reg_write_en, reg_write_addr, reg_write_data); end
      present(1, 1, 5'd0, 2'd2, 3'd0, 2'd0, 32'h11111111, 32'h22222222, 32'h00400010);
      step();
      c0 = m_count;
      n_cmp++; if (reg_write_en !== 1'b0) begin n_bad++; $display("FAIL zero_dst_en got %b want 0", reg_write_en); end
      present(0, 0, 5'd0, 2'd0, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0);
      step();
      n_cmp++; if (retire_count !== c0 + 32'd1 || retire_count !== m_count) begin
         n_bad++; $display("FAIL zero_dst_count got %0d want %0d", retire_count, c0 + 32'd1); end
   endtask

   task automatic test_flush_bubble();
      logic [31:0] c0;
      step();
      c0 = m_count;
      flush_i = 1'b1;
      present(1, 1, 5'd7, 2'd0, 3'd0, 2'd0, 32'h55AA55AA, 32'h0, 32'h0);
      step();
      flush_i = 1'b0;
      n_cmp++; if (reg_write_en !== 1'b0) begin n_bad++; $display("FAIL flush_en got %b want 0", reg_write_en); end
      present(0, 1, 5'd7, 2'd0, 3'd0, 2'd0, 32'h55AA55AA, 32'h0, 32'h0);
      step();
      n_cmp++; if (reg_write_en !== 1'b0) begin n_bad++; $display("FAIL bubble_en got %b want 0", reg_write_en); end
      step();
      n_cmp++; if (retire_count !== c0) begin n_bad++; $display("FAIL flush_count got %0d want %0d", retire_count, c0); end
   endtask

   task automatic test_reset_mid();
      present(1, 1, 5'd12, 2'd0, 3'd0, 2'd0, 32'hCAFEF00D, 32'h0, 32'h0);
      step();
      reset = 1'b0;
      present(1, 1, 5'd13, 2'd0, 3'd0, 2'd0, 32'h0BADC0DE, 32'h0, 32'h0);
      step();
      n_cmp++; if ({reg_write_en, reg_write_addr, reg_write_data, retire_count} !== '0) begin
         n_bad++; $display("FAIL midreset got en=%b addr=%0d data=%h count=%0d want all 0", reg_write_en, reg_write_addr, reg_write_data, retire_count); end
      reset = 1'b1;
      present(1, 1, 5'd14, 2'd0, 3'd0, 2'd0, 32'h13579BDF, 32'h0, 32'h0);
      step();
      n_cmp++; if (reg_write_en !== 1'b1 || reg_write_addr !== 5'd14 || reg_write_data !== 32'h13579BDF) begin
         n_bad++; $display("FAIL postreset got en=%b addr=%0d data=%h want en=1 addr=14 data=13579bdf", reg_write_en, reg_write_addr, reg_write_data); end
   endtask

   task automatic test_wrap();
      present(1, 1, 5'd5, 2'd0, 3'd0, 2'd0, 32'h1, 32'h0, 32'h0);
      step();
      force dut.retire_q = 32'hFFFFFFFF;
      #1;
      release dut.retire_q;
      m_count = 32'hFFFFFFFF;
      n_cmp++; if (retire_count !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL wrap_preload got %h want ffffffff", retire_count); end
      present(0, 0, 5'd0, 2'd0, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0);
      step();
      n_cmp++; if (retire_count !== 32'd0) begin n_bad++; $display("FAIL wrap got %h want 0", retire_count); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         reset   = ($urandom_range(0, 39) != 0);
         flush_i = ($urandom_range(0, 7) == 0);
         present($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)),
                 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                 $urandom, $urandom, $urandom);
         step();
         n_cmp++; if (reg_write_en !== m_en) begin n_bad++; $display("FAIL rnd_en[%0d] got %b want %b", i, reg_write_en, m_en); end
         n_cmp++; if (retire_count !== m_count) begin n_bad++; $display("FAIL rnd_count[%0d] got %0d want %0d", i, retire_count, m_count); end
         if (m_en) begin
            n_cmp++; if (reg_write_addr !== m_addr || reg_write_data !== m_data) begin
               n_bad++; $display("FAIL rnd_write[%0d] got %0d/%h want %0d/%h", i, reg_write_addr, reg_write_data, m_addr, m_data); end
         end
`ifdef WB_FWD_EN
         n_cmp++; if (fwd_valid !== m_en || (m_en && (fwd_addr !== m_addr || fwd_data !== m_data))) begin
            n_bad++; $display("FAIL rnd_fwd[%0d] got %b/%0d/%h want %b/%0d/%h", i, fwd_valid, fwd_addr, fwd_data, m_en, m_addr, m_data); end
`else
         n_cmp++; if ({fwd_valid, fwd_addr, fwd_data} !== '0) begin
            n_bad++; $display("FAIL rnd_fwd[%0d] got %b/%0d/%h want 0", i, fwd_valid, fwd_addr, fwd_data); end
`endif
      end
      reset = 1'b1;
      flush_i = 1'b0;
   endtask

   initial begin
      m_valid = 0; m_en = 0; m_addr = '0; m_data = '0; m_count = '0;
      reset = 1'b0; flush_i = 1'b0;
      present(0, 0, 5'd0, 2'd0, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0);
      #2;
      test_reset();
      test_alu();
      test_loads();
      test_link_zero();
      test_flush_bubble();
      test_reset_mid();
      test_wrap();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
